redirect_arbiter: RTL and testbench

Front-end redirect scheduler between the branch predictor, EX-stage branch resolution, exception flush, and the PC register. Arbitrates the three redirect sources by priority and holds one pending redirect while IF is stalled. After every corrective redirect it suppresses wrong-path predictor redirects for a programmable window. Keeps saturating statistics counters for performance debug.

---
 rtl/redirect_arbiter_if.sv | 37 +++
 rtl/redirect_arbiter.sv | 160 ++++++++++++++++
 tb/tb_redirect_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/redirect_arbiter_if.sv
// redirect_arbiter_if
//   Bundles the redirect scheduler's request and response signals.
//   slave  : the arbiter side (samples requests, drives redirect/stats).
//   master : the pipeline side (drives requests, observes redirect/stats).
//   Signals: stall[5:0], flush_req/flush_pc, br_e/br_target, bp_e/bp_target,
//            redirect_valid/redirect_pc/redirect_src, kill_front,
//            bp_cnt/br_cnt/drop_cnt (CNT_W bits each).
interface redirect_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       stall;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic             br_e;
    logic [31:0]      br_target;
    logic             bp_e;
    logic [31:0]      bp_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [1:0]       redirect_src;
    logic             kill_front;
    logic [CNT_W-1:0] bp_cnt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport slave (
        input  stall, flush_req, flush_pc, br_e, br_target, bp_e, bp_target,
        output redirect_valid, redirect_pc, redirect_src, kill_front,
               bp_cnt, br_cnt, drop_cnt
    );

    modport master (
        output stall, flush_req, flush_pc, br_e, br_target, bp_e, bp_target,
        input  redirect_valid, redirect_pc, redirect_src, kill_front,
               bp_cnt, br_cnt, drop_cnt
    );
endinterface

// File: rtl/redirect_arbiter.sv
// redirect_arbiter
//   Front-end redirect scheduler. Picks one of flush > br > bp each cycle,
//   holds a single pending redirect while IF is stalled, and after every
//   corrective (br/flush) redirect drops predictor redirects for SQUASH_CYC
//   unstalled cycles. Saturating statistics counters track issued bp/br
//   redirects and dropped bp requests.
//   Ports: clk, rst (synchronous, active-high), bus (redirect_arbiter_if.slave).
//   All outputs are registered; an accepted request appears one cycle later.
module redirect_arbiter #(
    parameter int unsigned SQUASH_CYC = 2,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    redirect_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PEND, SQUASH} state_t;
    typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_BP = 2'd1, SRC_BR = 2'd2, SRC_FLUSH = 2'd3} src_t;

    localparam logic [3:0] SQ_RELOAD = 4'(SQUASH_CYC);

    state_t           state_q, state_d;
    logic [3:0]       sqCnt_q, sqCnt_d;
    src_t             pendSrc_q, pendSrc_d;
    logic [31:0]      pendPc_q, pendPc_d;
    logic             valid_q, kill_q;
    src_t             src_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] bpCnt_q, brCnt_q, dropCnt_q;

    logic        stallIf;
    logic        issue;
    src_t        issueSrc;
    logic [31:0] issuePc;
    logic        bpDrop;
    src_t        candSrc;
    logic [31:0] candPc;

    assign stallIf = bus.stall[1];

    // Next-state and winner selection. A flush bypasses the stall and the
    // pending entry entirely; otherwise the candidate starts as the pending
    // entry and is replaced by an equal-or-higher priority request.
    always_comb begin
        state_d   = state_q;
        sqCnt_d   = sqCnt_q;
        pendSrc_d = pendSrc_q;
        pendPc_d  = pendPc_q;
        issue     = 1'b0;
        issueSrc  = SRC_NONE;
        issuePc   = 32'd0;
        bpDrop    = 1'b0;
        candSrc   = SRC_NONE;
        candPc    = 32'd0;

        if (bus.flush_req) begin
            issue     = 1'b1;
            issueSrc  = SRC_FLUSH;
            issuePc   = bus.flush_pc;
            bpDrop    = bus.bp_e;
            pendSrc_d = SRC_NONE;
            pendPc_d  = 32'd0;
            state_d   = SQUASH;
            sqCnt_d   = SQ_RELOAD;
        end else begin
            if (state_q == PEND) begin
                candSrc = pendSrc_q;
                candPc  = pendPc_q;
            end
            if (bus.br_e) begin
                candSrc = SRC_BR;
                candPc  = bus.br_target;
                bpDrop  = bus.bp_e;
            end else if (bus.bp_e) begin
                // bp loses to a pending br and is always wrong-path in SQUASH
                if (state_q == SQUASH || candSrc == SRC_BR) begin
                    bpDrop = 1'b1;
                end else begin
                    candSrc = SRC_BP;
                    candPc  = bus.bp_target;
                end
            end

            if (candSrc != SRC_NONE) begin
                if (!stallIf) begin
                    issue     = 1'b1;
                    issueSrc  = candSrc;
                    issuePc   = candPc;
                    pendSrc_d = SRC_NONE;
                    pendPc_d  = 32'd0;
                    if (candSrc == SRC_BR) begin
                        state_d = SQUASH;
                        sqCnt_d = SQ_RELOAD;
                    end else begin
                        state_d = IDLE;
                        sqCnt_d = 4'd0;
                    end
                end else begin
                    pendSrc_d = candSrc;
                    pendPc_d  = candPc;
                    state_d   = PEND;
                    sqCnt_d   = 4'd0;
                end
            end else if (state_q == SQUASH && !stallIf) begin
                // the window only counts cycles in which IF actually advances
                if (sqCnt_q <= 4'd1) begin
                    sqCnt_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    sqCnt_d = sqCnt_q - 4'd1;
                end
            end
        end
    end

    // State, pending entry, registered outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sqCnt_q    <= 4'd0;
            pendSrc_q  <= SRC_NONE;
            pendPc_q   <= 32'd0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            src_q      <= SRC_NONE;
            pc_q       <= 32'd0;
            bpCnt_q    <= '0;
            brCnt_q    <= '0;
            dropCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            sqCnt_q   <= sqCnt_d;
            pendSrc_q <= pendSrc_d;
            pendPc_q  <= pendPc_d;
            valid_q   <= issue;
            kill_q    <= issue && (issueSrc == SRC_BR || issueSrc == SRC_FLUSH);
            src_q     <= issueSrc;
            pc_q      <= issuePc;
            if (issue && issueSrc == SRC_BP && bpCnt_q != '1) begin
                bpCnt_q <= bpCnt_q + 1'b1;
            end
            if (issue && issueSrc == SRC_BR && brCnt_q != '1) begin
                brCnt_q <= brCnt_q + 1'b1;
            end
            if (bpDrop && dropCnt_q != '1) begin
                dropCnt_q <= dropCnt_q + 1'b1;
            end
        end
    end

    assign bus.redirect_valid = valid_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.redirect_src   = src_q;
    assign bus.kill_front     = kill_q;
    assign bus.bp_cnt         = bpCnt_q;
    assign bus.br_cnt         = brCnt_q;
    assign bus.drop_cnt       = dropCnt_q;

endmodule

// File: tb/tb_redirect_arbiter.sv
// tb_redirect_arbiter
//   Directed bench for redirect_arbiter. Two instances share the same
//   inputs: dutA with 16-bit counters and dutB with 4-bit counters so that
//   saturation is reachable. Expected redirects are queued with the cycle in
//   which they must appear; a negedge monitor pops and compares them.
module tb_redirect_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   nTests;
    int   nFail;

    typedef struct {
        int          cyc;
        logic [1:0]  src;
        logic [31:0] pc;
        logic        kill;
    } exp_t;

    exp_t expQ[$];

    redirect_arbiter_if #(.CNT_W(16)) busA ();
    redirect_arbiter_if #(.CNT_W(4))  busB ();

    assign busB.stall     = busA.stall;
    assign busB.flush_req = busA.flush_req;
    assign busB.flush_pc  = busA.flush_pc;
    assign busB.br_e      = busA.br_e;
    assign busB.br_target = busA.br_target;
    assign busB.bp_e      = busA.bp_e;
    assign busB.bp_target = busA.bp_target;

    redirect_arbiter #(.SQUASH_CYC(2), .CNT_W(16)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    redirect_arbiter #(.SQUASH_CYC(2), .CNT_W(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: value after edge N is N, and outputs registered at
    // edge N are observed at the following negedge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of requests, then advance past the sampling edge.
    task automatic applyStimulus(input logic stallIf,
                                 input logic fl, input logic [31:0] flPc,
                                 input logic br, input logic [31:0] brPc,
                                 input logic bp, input logic [31:0] bpPc);
        busA.stall     = {4'b0000, stallIf, 1'b0};
        busA.flush_req = fl;
        busA.flush_pc  = flPc;
        busA.br_e      = br;
        busA.br_target = brPc;
        busA.bp_e      = bp;
        busA.bp_target = bpPc;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic stallIf);
        for (int i = 0; i < n; i++) begin
            applyStimulus(stallIf, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        end
    endtask

    // The redirect must be on the outputs in the cycle following the edge
    // that just sampled the request.
    task automatic expectRedirect(input logic [1:0] src, input logic [31:0] pc, input logic kill);
        exp_t e;
        e.cyc  = cyc;
        e.src  = src;
        e.pc   = pc;
        e.kill = kill;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkCounters(input string tag, input int bpA, input int bpB,
                                 input int br, input int drop);
        checkOutput({tag, ".bpCntA"},   32'(busA.bp_cnt),   32'(bpA));
        checkOutput({tag, ".brCntA"},   32'(busA.br_cnt),   32'(br));
        checkOutput({tag, ".dropCntA"}, 32'(busA.drop_cnt), 32'(drop));
        checkOutput({tag, ".bpCntB"},   32'(busB.bp_cnt),   32'(bpB));
        checkOutput({tag, ".brCntB"},   32'(busB.br_cnt),   32'(br));
        checkOutput({tag, ".dropCntB"}, 32'(busB.drop_cnt), 32'(drop));
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation in
    // both content and cycle; a due expectation without a pulse is a miss;
    // outside a pulse the data outputs must read zero.
    always @(negedge clk) begin
        if (busA.redirect_valid === 1'b1) begin
            nTests++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL unexpectedRedirect: cyc %0d src %0d pc 0x%08h, expected no redirect",
                         cyc, busA.redirect_src, busA.redirect_pc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (e.cyc != cyc || busA.redirect_src !== e.src || busA.redirect_pc !== e.pc
                    || busA.kill_front !== e.kill) begin
                    nFail++;
                    $display("[TB] FAIL redirect: got cyc %0d src %0d pc 0x%08h kill %0b, expected cyc %0d src %0d pc 0x%08h kill %0b",
                             cyc, busA.redirect_src, busA.redirect_pc, busA.kill_front,
                             e.cyc, e.src, e.pc, e.kill);
                end
            end
        end else begin
            if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                exp_t e;
                e = expQ.pop_front();
                nTests++;
                nFail++;
                $display("[TB] FAIL missingRedirect: got no pulse at cyc %0d, expected src %0d pc 0x%08h",
                         cyc, e.src, e.pc);
            end
            if (busA.redirect_pc !== 32'd0 || busA.redirect_src !== 2'd0 || busA.kill_front !== 1'b0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL idleOutputs: got src %0d pc 0x%08h kill %0b, expected all zero",
                         busA.redirect_src, busA.redirect_pc, busA.kill_front);
            end
        end
    end

    initial begin
        nTests = 0;
        nFail  = 0;
        rst    = 1'b1;
        idleCycles(2, 1'b0);

        // reset state
        checkOutput("resetValid", 32'(busA.redirect_valid), 32'd0);
        checkOutput("resetPc",    busA.redirect_pc,         32'd0);
        checkOutput("resetSrc",   32'(busA.redirect_src),   32'd0);
        checkOutput("resetKill",  32'(busA.kill_front),     32'd0);
        checkCounters("reset", 0, 0, 0, 0);
        rst = 1'b0;
        idleCycles(1, 1'b0);

        // single predictor redirect
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000100);
        expectRedirect(2'd1, 32'h1c000100, 1'b0);
        checkCounters("singleBp", 1, 1, 0, 0);
        idleCycles(1, 1'b0);

        // flush, br and bp together: flush wins, bp counted as dropped
        applyStimulus(1'b0, 1'b1, 32'h1c008000, 1'b1, 32'h1c000200, 1'b1, 32'h1c000204);
        expectRedirect(2'd3, 32'h1c008000, 1'b1);
        checkCounters("simul", 1, 1, 0, 1);
        idleCycles(2, 1'b0);

        // br held under stall; bp in the second stall cycle is dropped
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h1c000300, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000999);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkCounters("stallHold", 1, 1, 0, 2);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expectRedirect(2'd2, 32'h1c000300, 1'b1);
        checkCounters("stallRelease", 1, 1, 1, 2);
        idleCycles(2, 1'b0);

        // squash window: a stalled cycle does not shorten it, then two bp
        // requests are dropped and the third issues
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h1c000400, 1'b0, 32'd0);
        expectRedirect(2'd2, 32'h1c000400, 1'b1);
        idleCycles(1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000500);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000504);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000508);
        expectRedirect(2'd1, 32'h1c000508, 1'b0);
        checkCounters("squash", 2, 2, 2, 4);
        idleCycles(1, 1'b0);

        // flush issues through a stall and discards the pending br
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h1c000600, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h1c00f000, 1'b0, 32'd0, 1'b0, 32'd0);
        expectRedirect(2'd3, 32'h1c00f000, 1'b1);
        idleCycles(2, 1'b1);
        idleCycles(3, 1'b0);
        checkCounters("flushStall", 2, 2, 2, 4);

        // equal priority: newest br target replaces the pending one
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h1c000700, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h1c000704, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expectRedirect(2'd2, 32'h1c000704, 1'b1);
        checkCounters("brOverwrite", 2, 2, 3, 4);
        idleCycles(2, 1'b0);

        // 20 back-to-back bp issues: dutB saturates at 15
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c001000 + 32'(i * 4));
            expectRedirect(2'd1, 32'h1c001000 + 32'(i * 4), 1'b0);
        end
        checkCounters("saturate", 22, 15, 3, 4);
        idleCycles(1, 1'b0);

        // reset while a br is pending: nothing issues afterwards
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h1c000900, 1'b0, 32'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("rstPendValid", 32'(busA.redirect_valid), 32'd0);
        checkOutput("rstPendPc",    busA.redirect_pc,         32'd0);
        checkCounters("rstPend", 0, 0, 0, 0);
        rst = 1'b0;
        idleCycles(4, 1'b0);
        checkOutput("postRstValid", 32'(busA.redirect_valid), 32'd0);

        idleCycles(2, 1'b0);
        checkOutput("pendingExpectations", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
